// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state type,
// default operand width and the counter-width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must hold M-1, so log2(M)+1 bits covers both powers of two and others.
  function automatic int cbit_for(input int m);
    return $clog2(m) + 1;
  endfunction

  localparam int M_DEF    = 8;
  localparam int CBIT_DEF = cbit_for(M_DEF);

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract datapath: working R/Q/D registers, the M+1-bit
// compare/subtract and the result registers that hold between operations.
module div_datapath
  import div_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic         step,
  input  logic         commit,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  logic [M-1:0] q_r;
  logic [M:0]   r_r;
  logic [M-1:0] d_r;
  logic [M-1:0] quotient_r;
  logic [M-1:0] remainder_r;
  logic         div_by_zero_r;

  logic [M:0]   t_s;
  logic [M:0]   d_ext_s;
  logic         ge_s;
  logic [M:0]   r_nxt_s;
  logic [M-1:0] q_nxt_s;

  // One restoring iteration: shift the next dividend bit into the partial remainder.
  always_comb begin
    t_s     = {r_r[M-1:0], q_r[M-1]};
    d_ext_s = {1'b0, d_r};
    ge_s    = 1'b0;
    r_nxt_s = t_s;
    if (t_s >= d_ext_s) begin
      ge_s    = 1'b1;
      r_nxt_s = t_s - d_ext_s;
    end else begin
      ge_s    = 1'b0;
      r_nxt_s = t_s;
    end
    q_nxt_s = {q_r[M-2:0], ge_s};
  end

  // Working registers: loaded on accepted start, advanced once per RUN cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
    end else if (load) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
    end else if (step) begin
      q_r <= q_nxt_s;
      r_r <= r_nxt_s;
    end else begin
      q_r <= q_r;
      r_r <= r_r;
      d_r <= d_r;
    end
  end

  // Result registers capture the final iteration directly, so they are valid with done.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
    end else if (commit) begin
      quotient_r    <= q_nxt_s;
      remainder_r   <= r_nxt_s[M-1:0];
      div_by_zero_r <= (d_r == '0);
    end else begin
      quotient_r    <= quotient_r;
      remainder_r   <= remainder_r;
      div_by_zero_r <= div_by_zero_r;
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider top: start/done handshake FSM and iteration
// counter around the restoring datapath; one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int CBIT = CBIT_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  div_state_e      state_r;
  div_state_e      state_nxt_s;
  logic [CBIT-1:0] cnt_r;
  logic            last_s;
  logic            load_s;
  logic            step_s;
  logic            commit_s;
  logic            busy_r;
  logic            done_r;

  assign last_s = (cnt_r == CBIT'(M - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = start;
      end
      RUN: begin
        step_s   = 1'b1;
        commit_s = last_s;
      end
      DONE: begin
        load_s = 1'b0;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Iteration counter: cleared on load, wraps to zero after the last step.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= '0;
    end else if (step_s) begin
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CBIT'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Handshake outputs are registered from the next state, keeping start off any comb path.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= (state_nxt_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;

  div_datapath #(
    .M(M)
  ) u_datapath (
    .clk         (clk),
    .nrst        (nrst),
    .load        (load_s),
    .step        (step_s),
    .commit      (commit_s),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at M=8 (directed + random) and M=16 (random),
// checked against plain '/' and '%' arithmetic.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned due;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int checks = 0;
  int errors = 0;

  logic        nrst8, st8, busy8, done8, dz8;
  logic [7:0]  dvd8, dvs8, quo8, rem8;
  logic        nrst16, st16, busy16, done16, dz16;
  logic [15:0] dvd16, dvs16, quo16, rem16;

  seq_divider #(.M(8), .CBIT(4)) u8 (
    .clk(clk), .nrst(nrst8), .start(st8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dz8)
  );

  seq_divider #(.M(16), .CBIT(5)) u16 (
    .clk(clk), .nrst(nrst16), .start(st16), .dividend(dvd16), .divisor(dvs16),
    .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16), .div_by_zero(dz16)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference: ordinary integer division; zero divisor yields all-ones / dividend.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                 input int m, input int unsigned due);
    exp_t e;
    e.a = a;
    e.d = d;
    e.due = due;
    if (d == 32'd0) begin
      e.q  = (32'd1 << m) - 32'd1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / d;
      e.r  = a % d;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e, input logic [31:0] q,
                              input logic [31:0] r, input logic dz, input logic bsy);
    chk({tag, "_quotient"}, q, e.q);
    chk({tag, "_remainder"}, r, e.r);
    chk({tag, "_dbz"}, 32'(dz), 32'(e.dz));
    chk({tag, "_latency"}, cyc, e.due);
    chk({tag, "_busy_at_done"}, 32'(bsy), 32'd1);
    if (e.d != 32'd0) begin
      chk({tag, "_recon"}, q * e.d + r, e.a);
      chk({tag, "_r_lt_d"}, 32'(r < e.d), 32'd1);
    end
  endtask

  // Monitors: every done pops one expectation; a done with nothing pending is an error.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (nrst8 && done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL m8_unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        check_result("m8", e, 32'(quo8), 32'(rem8), dz8, busy8);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (nrst16 && done16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL m16_unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        e = q16.pop_front();
        check_result("m16", e, 32'(quo16), 32'(rem16), dz16, busy16);
      end
    end
  end

  // Issue an accepted start (caller guarantees idle) and queue its expected result.
  task automatic go8(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    dvd8 = a; dvs8 = d; st8 = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back(model(32'(a), 32'(d), 8, cyc + 8));
    @(negedge clk);
    st8 = 1'b0;
    dvd8 = 8'($urandom); dvs8 = 8'($urandom);
  endtask

  task automatic wait8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      checks++; errors++;
      $display("FAIL m8_timeout: got %0d pending expected 0", q8.size());
      q8.delete();
    end
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    dvd16 = a; dvs16 = d; st16 = 1'b1;
    @(posedge clk);
    #1;
    q16.push_back(model(32'(a), 32'(d), 16, cyc + 16));
    @(negedge clk);
    st16 = 1'b0;
    dvd16 = 16'($urandom); dvs16 = 16'($urandom);
  endtask

  task automatic wait16();
    for (int i = 0; i < 60 && q16.size() != 0; i++) @(negedge clk);
    if (q16.size() != 0) begin
      checks++; errors++;
      $display("FAIL m16_timeout: got %0d pending expected 0", q16.size());
      q16.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst8 = 1'b0; st8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
    nrst16 = 1'b0; st16 = 1'b0; dvd16 = 16'd0; dvs16 = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_quotient", 32'(quo8), 32'd0);
    chk("rst_remainder", 32'(rem8), 32'd0);
    chk("rst_dbz", 32'(dz8), 32'd0);
    nrst8 = 1'b1; nrst16 = 1'b1;

    fork
      begin : drv8
        int bc;
        // 100/7 with busy length measured from the first busy cycle.
        go8(8'd100, 8'd7);
        bc = 0;
        for (int i = 0; i < 14; i++) begin
          if (busy8) bc++;
          @(negedge clk);
        end
        chk("busy_len", 32'(bc), 32'd9);
        wait8();

        go8(8'd255, 8'd1);   wait8();
        go8(8'd5, 8'd9);     wait8();
        go8(8'd255, 8'd255); wait8();
        go8(8'd200, 8'd0);   wait8();
        go8(8'd9, 8'd3);     wait8();

        // Starts during RUN and DONE are ignored; one in the following idle cycle is taken.
        go8(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        st8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
        @(negedge clk);
        st8 = 1'b0;
        repeat (5) @(negedge clk);
        st8 = 1'b1;
        go8(8'd50, 8'd5);
        wait8();

        // Reset mid-operation: no done, outputs cleared.
        go8(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        nrst8 = 1'b0;
        q8.delete();
        @(negedge clk);
        nrst8 = 1'b1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_quotient", 32'(quo8), 32'd0);
        chk("abort_remainder", 32'(rem8), 32'd0);
        chk("abort_dbz", 32'(dz8), 32'd0);
        repeat (12) @(negedge clk);

        // start held under reset never leaves idle.
        nrst8 = 1'b0; st8 = 1'b1; dvd8 = 8'd77; dvs8 = 8'd3;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("rst_hold_busy", 32'(busy8), 32'd0);
        end
        st8 = 1'b0;
        nrst8 = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_hold_after", 32'(busy8), 32'd0);

        for (int n = 0; n < 1000; n++) begin
          logic [7:0] a, d;
          a = 8'($urandom);
          d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
          go8(a, d);
          wait8();
        end
      end
      begin : drv16
        go16(16'hFFFF, 16'd1);      wait16();
        go16(16'hFFFF, 16'hFFFF);   wait16();
        go16(16'd1234, 16'd0);      wait16();
        go16(16'd3, 16'd40000);     wait16();
        for (int n = 0; n < 300; n++) begin
          logic [15:0] a, d;
          a = 16'($urandom);
          d = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
          go16(a, d);
          wait16();
        end
      end
    join

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
